// File: rtl/avalmm_scope_regbank.sv
// -----------------------------------------------------------------------------
// avalmm_scope_regbank
//
// Avalon-MM slave register bank for the oscilloscope datapath. It sits between
// the Nios II Qsys fabric and the per-channel acquisition/measurement blocks.
// It holds the global trigger/acquisition controls, the per-channel display
// shift/scale controls, a coherent amplitude snapshot per channel, sticky
// trigger flags (write-1-to-clear) and a maskable level interrupt.
//
// Bus handshake:
//   A read is accepted in every cycle in which avalon_read is high. No wait
//   states are used. avalon_readdata is registered, and avalon_readdatavalid
//   pulses for exactly one cycle, one clock after each read cycle. Back-to-back
//   reads therefore stream at full rate. A write takes effect at the clock
//   edge of its cycle, lane by lane under avalon_byteenable. When read and
//   write are both high, the read is served and the write is dropped.
//
// Address map (word addresses):
//   0 VERSION (read-only)       1 STATUS (W1C sticky trigger flags)
//   2 IRQ_MASK                  3 CTRL {trig_src[4:2], trig_edge[1], wave_run[0]}
//   4 deci_rate[9:0]            5 {trig_line[15:8], trig_level[SMP_W-1:0]}
//   8+4c+0 FREQ_c (live freq; the read also latches the amplitude snapshot)
//   8+4c+1 AMP_c  {8'd0, vpp, max, min} taken from the snapshot
//   8+4c+2 SHIFT_c {v_shift[25:16], h_shift[9:0]}
//   8+4c+3 SCALE_c v_scale[4:0]
//   Any other address reads as 0 and ignores writes.
//
// Ports:
//   sys_clk, rst              clock and asynchronous active-high reset
//   avalon_*                  Avalon-MM slave port (word addressed)
//   irq                       level interrupt, |(status & irq_mask), registered
//   ad_freq/ad_vpp/ad_max/ad_min  per-channel measurements, packed by channel
//   trig_evt                  per-channel one-cycle trigger pulses
//   deci_rate .. v_scale      control outputs to the acquisition datapath
// -----------------------------------------------------------------------------
module avalmm_scope_regbank #(
  parameter int          NUM_CH  = 2,
  parameter int          FREQ_W  = 20,
  parameter int          SMP_W   = 8,
  parameter int          ADDR_W  = 5,
  parameter logic [31:0] VERSION = 32'h0002_0000
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         avalon_address,
  input  logic                      avalon_read,
  input  logic                      avalon_write,
  input  logic [31:0]               avalon_writedata,
  input  logic [3:0]                avalon_byteenable,
  output logic [31:0]               avalon_readdata,
  output logic                      avalon_readdatavalid,
  output logic                      irq,
  input  logic [NUM_CH*FREQ_W-1:0]  ad_freq,
  input  logic [NUM_CH*SMP_W-1:0]   ad_vpp,
  input  logic [NUM_CH*SMP_W-1:0]   ad_max,
  input  logic [NUM_CH*SMP_W-1:0]   ad_min,
  input  logic [NUM_CH-1:0]         trig_evt,
  output logic [9:0]                deci_rate,
  output logic [SMP_W-1:0]          trig_level,
  output logic [7:0]                trig_line,
  output logic                      trig_edge,
  output logic [2:0]                trig_src,
  output logic                      wave_run,
  output logic [NUM_CH*10-1:0]      h_shift,
  output logic [NUM_CH*10-1:0]      v_shift,
  output logic [NUM_CH*5-1:0]       v_scale
);

  // ---------------------------------------------------------------------------
  // Address constants
  // ---------------------------------------------------------------------------
  localparam logic [ADDR_W-1:0] A_VERSION  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_IRQ_MASK = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_DECI     = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_TRIG     = ADDR_W'(5);

  localparam logic [SMP_W-1:0]  TRIG_LEVEL_RST = SMP_W'(1) << (SMP_W - 1);
  localparam logic [2:0]        SRC_MAX        = 3'(NUM_CH - 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [9:0]                r_deci_rate;
  logic [SMP_W-1:0]          r_trig_level;
  logic [7:0]                r_trig_line;
  logic                      r_trig_edge;
  logic [2:0]                r_trig_src;
  logic                      r_wave_run;
  logic [NUM_CH-1:0]         r_status;
  logic [NUM_CH-1:0]         r_irq_mask;
  logic                      r_irq;
  logic [NUM_CH*10-1:0]      r_h_shift;
  logic [NUM_CH*10-1:0]      r_v_shift;
  logic [NUM_CH*5-1:0]       r_v_scale;
  logic [NUM_CH*SMP_W-1:0]   r_snap_vpp;
  logic [NUM_CH*SMP_W-1:0]   r_snap_max;
  logic [NUM_CH*SMP_W-1:0]   r_snap_min;
  logic [31:0]               r_readdata;
  logic                      r_readdatavalid;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // Replace only the enabled byte lanes of a register image.
  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Zero-extend a sample to 10 bits (SMP_W <= 10) and keep the low byte.
  function automatic logic [7:0] f_lo8(input logic [SMP_W-1:0] v);
    logic [9:0] t;
    t = 10'(v);
    return t[7:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Write qualification and byte-lane merge
  // ---------------------------------------------------------------------------
  logic        w_wr;
  logic [31:0] w_be_mask;

  // A write that coincides with a read is discarded.
  assign w_wr = avalon_write & ~avalon_read;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_be_mask[8*i +: 8] = {8{avalon_byteenable[i]}};
    end
  end

  // Current register images, laid out exactly as they read back, so that a
  // merge leaves field bits in disabled lanes untouched.
  logic [31:0] w_img_ctrl, w_img_deci, w_img_trig, w_img_mask;
  logic [31:0] w_new_ctrl, w_new_deci, w_new_trig, w_new_mask;
  logic [2:0]  w_src_raw, w_src_clamped;

  // trig_level is ORed in: for SMP_W > 8 its top bits share the trig_line lane.
  assign w_img_ctrl = {27'd0, r_trig_src, r_trig_edge, r_wave_run};
  assign w_img_deci = {22'd0, r_deci_rate};
  assign w_img_trig = {16'd0, r_trig_line, 8'd0} | 32'(r_trig_level);
  assign w_img_mask = 32'(r_irq_mask);

  assign w_new_ctrl = f_merge(w_img_ctrl, avalon_writedata, w_be_mask);
  assign w_new_deci = f_merge(w_img_deci, avalon_writedata, w_be_mask);
  assign w_new_trig = f_merge(w_img_trig, avalon_writedata, w_be_mask);
  assign w_new_mask = f_merge(w_img_mask, avalon_writedata, w_be_mask);

  // Only existing channels can be selected as the trigger source.
  assign w_src_raw     = w_new_ctrl[4:2];
  assign w_src_clamped = (w_src_raw > SRC_MAX) ? SRC_MAX : w_src_raw;

  // ---------------------------------------------------------------------------
  // Per-channel decode and images
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] w_sel_freq, w_sel_amp, w_sel_shift, w_sel_scale;
  logic [31:0]       w_new_shift [NUM_CH];
  logic [31:0]       w_new_scale [NUM_CH];

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_sel_freq[c]  = (avalon_address == ADDR_W'(8 + 4*c + 0));
      w_sel_amp[c]   = (avalon_address == ADDR_W'(8 + 4*c + 1));
      w_sel_shift[c] = (avalon_address == ADDR_W'(8 + 4*c + 2));
      w_sel_scale[c] = (avalon_address == ADDR_W'(8 + 4*c + 3));
      w_new_shift[c] = f_merge({6'd0, r_v_shift[c*10 +: 10], 6'd0, r_h_shift[c*10 +: 10]},
                               avalon_writedata, w_be_mask);
      w_new_scale[c] = f_merge({27'd0, r_v_scale[c*5 +: 5]},
                               avalon_writedata, w_be_mask);
    end
  end

  // ---------------------------------------------------------------------------
  // Global control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_deci_rate  <= 10'd2;
      r_trig_level <= TRIG_LEVEL_RST;
      r_trig_line  <= 8'd148;
      r_trig_edge  <= 1'b0;
      r_trig_src   <= 3'd0;
      r_wave_run   <= 1'b1;
      r_irq_mask   <= '0;
    end else if (w_wr) begin
      case (avalon_address)
        A_IRQ_MASK: r_irq_mask <= w_new_mask[NUM_CH-1:0];
        A_CTRL: begin
          r_wave_run  <= w_new_ctrl[0];
          r_trig_edge <= w_new_ctrl[1];
          r_trig_src  <= w_src_clamped;
        end
        A_DECI:     r_deci_rate <= w_new_deci[9:0];
        A_TRIG: begin
          r_trig_level <= w_new_trig[SMP_W-1:0];
          r_trig_line  <= w_new_trig[15:8];
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel shift/scale registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_h_shift <= '0;
      r_v_shift <= '0;
      r_v_scale <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr && w_sel_shift[c]) begin
          r_h_shift[c*10 +: 10] <= w_new_shift[c][9:0];
          r_v_shift[c*10 +: 10] <= w_new_shift[c][25:16];
        end
        if (w_wr && w_sel_scale[c]) begin
          r_v_scale[c*5 +: 5] <= w_new_scale[c][4:0];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Measurement snapshot: reading FREQ_c freezes vpp/max/min of channel c so a
  // following AMP_c read belongs to the same instant as the frequency value.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_snap_vpp <= '0;
      r_snap_max <= '0;
      r_snap_min <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (avalon_read && w_sel_freq[c]) begin
          r_snap_vpp[c*SMP_W +: SMP_W] <= ad_vpp[c*SMP_W +: SMP_W];
          r_snap_max[c*SMP_W +: SMP_W] <= ad_max[c*SMP_W +: SMP_W];
          r_snap_min[c*SMP_W +: SMP_W] <= ad_min[c*SMP_W +: SMP_W];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky trigger flags and interrupt. A new event wins over a coincident
  // clear because the set term is ORed in after the clear.
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] w_clr;

  assign w_clr = (w_wr && (avalon_address == A_STATUS))
               ? (avalon_writedata[NUM_CH-1:0] & w_be_mask[NUM_CH-1:0])
               : '0;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_status <= (r_status & ~w_clr) | trig_evt;
      r_irq    <= |(r_status & r_irq_mask);
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    case (avalon_address)
      A_VERSION:  w_rdata = VERSION;
      A_STATUS:   w_rdata = 32'(r_status);
      A_IRQ_MASK: w_rdata = w_img_mask;
      A_CTRL:     w_rdata = w_img_ctrl;
      A_DECI:     w_rdata = w_img_deci;
      A_TRIG:     w_rdata = w_img_trig;
      default:    ;
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_sel_freq[c]) begin
        w_rdata = 32'(ad_freq[c*FREQ_W +: FREQ_W]);
      end
      if (w_sel_amp[c]) begin
        w_rdata = {8'd0,
                   f_lo8(r_snap_vpp[c*SMP_W +: SMP_W]),
                   f_lo8(r_snap_max[c*SMP_W +: SMP_W]),
                   f_lo8(r_snap_min[c*SMP_W +: SMP_W])};
      end
      if (w_sel_shift[c]) begin
        w_rdata = {6'd0, r_v_shift[c*10 +: 10], 6'd0, r_h_shift[c*10 +: 10]};
      end
      if (w_sel_scale[c]) begin
        w_rdata = {27'd0, r_v_scale[c*5 +: 5]};
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
    end else begin
      r_readdatavalid <= avalon_read;
      if (avalon_read) begin
        r_readdata <= w_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign avalon_readdata      = r_readdata;
  assign avalon_readdatavalid = r_readdatavalid;
  assign irq                  = r_irq;
  assign deci_rate            = r_deci_rate;
  assign trig_level           = r_trig_level;
  assign trig_line            = r_trig_line;
  assign trig_edge            = r_trig_edge;
  assign trig_src             = r_trig_src;
  assign wave_run             = r_wave_run;
  assign h_shift              = r_h_shift;
  assign v_shift              = r_v_shift;
  assign v_scale              = r_v_scale;

endmodule

// File: tb/tb_avalmm_scope_regbank.sv
// -----------------------------------------------------------------------------
// tb_avalmm_scope_regbank
//
// Self-checking bench for avalmm_scope_regbank with default parameters.
// Read expectations are queued when a read is driven and compared when
// readdatavalid is seen; readdatavalid timing is checked every cycle.
// -----------------------------------------------------------------------------
module tb_avalmm_scope_regbank;

  localparam int NUM_CH = 2;
  localparam int FREQ_W = 20;
  localparam int SMP_W  = 8;
  localparam int ADDR_W = 5;
  localparam logic [31:0] VERSION = 32'h0002_0000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  always #5 sys_clk = ~sys_clk;

  logic [ADDR_W-1:0]        avalon_address = '0;
  logic                     avalon_read = 1'b0;
  logic                     avalon_write = 1'b0;
  logic [31:0]              avalon_writedata = '0;
  logic [3:0]               avalon_byteenable = '0;
  logic [31:0]              avalon_readdata;
  logic                     avalon_readdatavalid;
  logic                     irq;
  logic [NUM_CH*FREQ_W-1:0] ad_freq = '0;
  logic [NUM_CH*SMP_W-1:0]  ad_vpp = '0;
  logic [NUM_CH*SMP_W-1:0]  ad_max = '0;
  logic [NUM_CH*SMP_W-1:0]  ad_min = '0;
  logic [NUM_CH-1:0]        trig_evt = '0;
  logic [9:0]               deci_rate;
  logic [SMP_W-1:0]         trig_level;
  logic [7:0]               trig_line;
  logic                     trig_edge;
  logic [2:0]               trig_src;
  logic                     wave_run;
  logic [NUM_CH*10-1:0]     h_shift;
  logic [NUM_CH*10-1:0]     v_shift;
  logic [NUM_CH*5-1:0]      v_scale;

  avalmm_scope_regbank #(
    .NUM_CH(NUM_CH), .FREQ_W(FREQ_W), .SMP_W(SMP_W), .ADDR_W(ADDR_W), .VERSION(VERSION)
  ) dut (
    .sys_clk(sys_clk), .rst(rst),
    .avalon_address(avalon_address), .avalon_read(avalon_read),
    .avalon_write(avalon_write), .avalon_writedata(avalon_writedata),
    .avalon_byteenable(avalon_byteenable), .avalon_readdata(avalon_readdata),
    .avalon_readdatavalid(avalon_readdatavalid), .irq(irq),
    .ad_freq(ad_freq), .ad_vpp(ad_vpp), .ad_max(ad_max), .ad_min(ad_min),
    .trig_evt(trig_evt), .deci_rate(deci_rate), .trig_level(trig_level),
    .trig_line(trig_line), .trig_edge(trig_edge), .trig_src(trig_src),
    .wave_run(wave_run), .h_shift(h_shift), .v_shift(v_shift), .v_scale(v_scale)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / checking
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // A read driven at a posedge must produce readdatavalid for the next cycle.
  logic rd_seen;
  always @(posedge sys_clk or posedge rst) begin
    if (rst) rd_seen <= 1'b0;
    else     rd_seen <= avalon_read;
  end

  always @(negedge sys_clk) begin
    check("rdvalid", 32'(avalon_readdatavalid), 32'(rd_seen));
    if (avalon_readdatavalid) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 32'd1, 32'd0);
      end else begin
        check("rdata", avalon_readdata, exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all entered at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic bus_read(input int addr, input logic [31:0] exp);
    avalon_address = ADDR_W'(addr);
    avalon_read    = 1'b1;
    exp_q.push_back(exp);
    @(posedge sys_clk); #1;
    avalon_read    = 1'b0;
  endtask

  task automatic bus_write(input int addr, input logic [31:0] data, input logic [3:0] be);
    avalon_address    = ADDR_W'(addr);
    avalon_writedata  = data;
    avalon_byteenable = be;
    avalon_write      = 1'b1;
    @(posedge sys_clk); #1;
    avalon_write      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_deci"},   32'(deci_rate), 32'd2);
    check({pfx, "_level"},  32'(trig_level), 32'd128);
    check({pfx, "_line"},   32'(trig_line), 32'd148);
    check({pfx, "_edge"},   32'(trig_edge), 32'd0);
    check({pfx, "_src"},    32'(trig_src), 32'd0);
    check({pfx, "_run"},    32'(wave_run), 32'd1);
    check({pfx, "_hshift"}, 32'(h_shift), 32'd0);
    check({pfx, "_vshift"}, 32'(v_shift), 32'd0);
    check({pfx, "_vscale"}, 32'(v_scale), 32'd0);
    check({pfx, "_irq"},    32'(irq), 32'd0);
    check({pfx, "_rdv"},    32'(avalon_readdatavalid), 32'd0);
    check({pfx, "_rdata"},  avalon_readdata, 32'd0);
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  // Reference images of the per-channel shift/scale registers.
  logic [31:0] m_shift [NUM_CH];
  logic [31:0] m_scale [NUM_CH];

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      m_shift[c] = '0;
      m_scale[c] = '0;
    end
    #22;
    check_reset_outputs("rst0");
    rst = 1'b0;
    @(posedge sys_clk); #1;

    // Reset values through the bus, back to back.
    bus_read(4, 32'd2);
    bus_read(5, 32'h0000_9480);
    bus_read(3, 32'h0000_0001);
    bus_read(0, VERSION);
    bus_read(1, 32'd0);
    bus_read(2, 32'd0);

    // Lane-selective writes.
    bus_write(5, 32'h0000_5A40, 4'b0010);
    check("trig_line_5a", 32'(trig_line), 32'h5A);
    check("trig_level_kept", 32'(trig_level), 32'd128);
    bus_write(5, 32'h0000_FF33, 4'b0001);
    check("trig_level_33", 32'(trig_level), 32'h33);
    bus_read(5, 32'h0000_5A33);
    bus_write(4, 32'h0000_03FF, 4'b0010);
    check("deci_lane1", 32'(deci_rate), 32'h302);

    // Coherent snapshot of channel 1.
    ad_freq[1*FREQ_W +: FREQ_W] = 20'h1_2345;
    ad_vpp[1*SMP_W +: SMP_W] = 8'h30;
    ad_max[1*SMP_W +: SMP_W] = 8'h90;
    ad_min[1*SMP_W +: SMP_W] = 8'h60;
    ad_vpp[0*SMP_W +: SMP_W] = 8'h11;
    bus_read(12, 32'h0001_2345);
    ad_freq[1*FREQ_W +: FREQ_W] = 20'hA_BCDE;
    ad_vpp[1*SMP_W +: SMP_W] = 8'h01;
    ad_max[1*SMP_W +: SMP_W] = 8'h02;
    ad_min[1*SMP_W +: SMP_W] = 8'h03;
    bus_read(13, 32'h0030_9060);
    bus_read(12, 32'h000A_BCDE);
    bus_read(9, 32'd0);
    bus_read(13, 32'h0001_0203);

    // Sticky flags and interrupt.
    bus_write(2, 32'h0000_0001, 4'b1111);
    trig_evt = 2'b01;
    @(posedge sys_clk); #1;
    trig_evt = 2'b00;
    check("irq_lag", 32'(irq), 32'd0);
    @(posedge sys_clk); #1;
    check("irq_set", 32'(irq), 32'd1);
    bus_read(1, 32'd1);
    avalon_address = ADDR_W'(1);
    avalon_writedata = 32'h1;
    avalon_byteenable = 4'hF;
    avalon_write = 1'b1;
    trig_evt = 2'b01;
    @(posedge sys_clk); #1;
    avalon_write = 1'b0;
    trig_evt = 2'b00;
    bus_read(1, 32'd1);
    check("irq_hold", 32'(irq), 32'd1);
    bus_write(1, 32'h0000_0001, 4'b1111);
    idle(1);
    check("irq_clear", 32'(irq), 32'd0);
    bus_read(1, 32'd0);
    trig_evt = 2'b10;
    @(posedge sys_clk); #1;
    trig_evt = 2'b00;
    idle(1);
    check("irq_masked", 32'(irq), 32'd0);
    bus_read(1, 32'd2);
    bus_write(1, 32'h0000_0002, 4'b0000);
    bus_read(1, 32'd2);
    bus_write(1, 32'h0000_0002, 4'b0001);
    bus_read(1, 32'd0);

    // CTRL clamp and read/write collision.
    bus_write(3, 32'h0000_001E, 4'b1111);
    check("src_clamp", 32'(trig_src), 32'd1);
    check("edge_set", 32'(trig_edge), 32'd1);
    check("run_clr", 32'(wave_run), 32'd0);
    bus_read(3, 32'h0000_0006);
    avalon_address = ADDR_W'(4);
    avalon_writedata = 32'h0000_0055;
    avalon_byteenable = 4'hF;
    avalon_write = 1'b1;
    avalon_read = 1'b1;
    exp_q.push_back(32'h302);
    @(posedge sys_clk); #1;
    avalon_write = 1'b0;
    avalon_read = 1'b0;
    check("rw_deci_kept", 32'(deci_rate), 32'h302);

    // Unlisted addresses.
    bus_write(7, 32'hFFFF_FFFF, 4'hF);
    bus_write(16, 32'hFFFF_FFFF, 4'hF);
    bus_read(6, 32'd0);
    bus_read(7, 32'd0);
    bus_read(16, 32'd0);
    bus_write(0, 32'hFFFF_FFFF, 4'hF);
    bus_read(0, VERSION);

    // Random shift/scale writes with random byte enables.
    for (int k = 0; k < 24; k++) begin
      int c;
      logic [31:0] d;
      logic [3:0]  be;
      c  = $urandom_range(NUM_CH - 1, 0);
      d  = $urandom();
      be = 4'($urandom_range(15, 0));
      if ($urandom_range(1, 0) == 1) begin
        bus_write(8 + 4*c + 2, d, be);
        m_shift[c] = lane_merge(m_shift[c], d, be) & 32'h03FF_03FF;
      end else begin
        bus_write(8 + 4*c + 3, d, be);
        m_scale[c] = lane_merge(m_scale[c], d, be) & 32'h0000_001F;
      end
      check("h_shift", 32'(h_shift[c*10 +: 10]), 32'(m_shift[c][9:0]));
      check("v_shift", 32'(v_shift[c*10 +: 10]), 32'(m_shift[c][25:16]));
      check("v_scale", 32'(v_scale[c*5 +: 5]), 32'(m_scale[c][4:0]));
      bus_read(8 + 4*c + 2, m_shift[c]);
      bus_read(8 + 4*c + 3, m_scale[c]);
    end

    // Reset with a readdatavalid pending.
    avalon_address = ADDR_W'(4);
    avalon_read = 1'b1;
    @(posedge sys_clk); #1;
    avalon_read = 1'b0;
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset_outputs("rst1");
    @(posedge sys_clk); #1;
    rst = 1'b0;
    idle(2);
    bus_read(4, 32'd2);
    bus_read(1, 32'd0);

    // Drain outstanding reads within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle(1);
    check("drain", 32'(exp_q.size()), 32'd0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
